// File: rtl/rv_print_pkg.sv
// Shared constants and UART state encoding for the print side-band consumer.
package rv_print_pkg;
    localparam int PRINT_W        = 49;
    localparam int PRINT_STB_BIT  = 48;
    localparam int PRINT_CHAR_MSB = 7;

    typedef logic [1:0] uart_state_t;
    localparam uart_state_t IDLE  = 2'd0;
    localparam uart_state_t START = 2'd1;
    localparam uart_state_t DATA  = 2'd2;
    localparam uart_state_t STOP  = 2'd3;
endpackage

// File: rtl/print_fifo.sv
// Character FIFO with extra-MSB pointers; the caller guarantees push is only legal when space exists.
module print_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; flushing the pointers is enough to discard contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
endmodule

// File: rtl/print_uart_tx.sv
// Buffers print side-band characters and serialises them as UART 8N1, counting drops on overflow.
module print_uart_tx
    import rv_print_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 4,
    parameter int DROP_W       = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [PRINT_W-1:0]   print_out,
    output logic                 uart_tx,
    output logic                 busy,
    output logic [FIFO_AW:0]     fifo_level,
    output logic                 overflow,
    output logic [DROP_W-1:0]    drop_cnt
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    uart_state_t   state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          stb, push, pop, drop, full, empty, baud_last;
    logic [7:0]    ch, head;
    logic          unused_bits;

    assign stb         = print_out[PRINT_STB_BIT];
    assign ch          = print_out[PRINT_CHAR_MSB:0];
    assign unused_bits = ^print_out[PRINT_STB_BIT-1:PRINT_CHAR_MSB+1];

    assign baud_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    // Popping on the last stop cycle chains frames with no idle gap.
    assign pop  = !empty && ((state == IDLE) || (state == STOP && baud_last));
    assign push = stb && (!full || pop);
    assign drop = stb && full && !pop;

    print_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (ch),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    shreg    <= head;
                    uart_tx  <= 1'b0;
                    baud_cnt <= '0;
                    state    <= START;
                end
                START: if (baud_last) begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    uart_tx  <= shreg[0];
                    state    <= DATA;
                end else baud_cnt <= baud_cnt + 1'b1;
                DATA: if (baud_last) begin
                    baud_cnt <= '0;
                    if (bit_cnt == 3'd7) begin
                        uart_tx <= 1'b1;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= shreg >> 1;
                        uart_tx <= shreg[1];
                    end
                end else baud_cnt <= baud_cnt + 1'b1;
                default: if (baud_last) begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shreg   <= head;
                        uart_tx <= 1'b0;
                        state   <= START;
                    end else state <= IDLE;
                end else baud_cnt <= baud_cnt + 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign busy = (state != IDLE) || (fifo_level != '0);
endmodule
